// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and register file.
// Covers the default widths, the WB control bit positions and the hardwired-zero register index.
package wb_regfile_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;
  localparam int REG_ZERO    = 0;
endpackage

// File: rtl/wb_reg_array.sv
// Register storage: 2**ADDR_W x DATA_W, synchronous clear, one write port, two async reads.
// Index REG_ZERO is never written and always reads as zero.
module wb_reg_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset dominates any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != ZERO_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == ZERO_IDX) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == ZERO_IDX) ? '0 : mem[raddr_b];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, effective write enable and architectural register file.
// Define WB_REGFILE_BYPASS_EN for same-cycle write-through on both read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [DATA_W-1:0] immed_i,
  input  logic [ADDR_W-1:0] mux3_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic              WBwe_o
);
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [DATA_W-1:0] rs_stored;
  logic [DATA_W-1:0] rt_stored;

  assign wb_data = WB_i[WB_MEMTOREG] ? ReadData_i : immed_i;
  assign wb_we   = WB_i[WB_REGWRITE] && (mux3_i != ADDR_W'(REG_ZERO));

  assign WBdata_o = wb_data;
  assign WBwe_o   = wb_we;

  wb_reg_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk_i),
    .rst     (rst_i),
    .we      (wb_we),
    .waddr   (mux3_i),
    .wdata   (wb_data),
    .raddr_a (RSaddr_i),
    .raddr_b (RTaddr_i),
    .rdata_a (rs_stored),
    .rdata_b (rt_stored)
  );

`ifdef WB_REGFILE_BYPASS_EN
  // Write-through hides the WB->ID hazard; suppressed while the file is being cleared.
  logic bypass_ok;
  assign bypass_ok = wb_we && !rst_i;
  assign RSdata_o  = (bypass_ok && (RSaddr_i == mux3_i)) ? wb_data : rs_stored;
  assign RTdata_o  = (bypass_ok && (RTaddr_i == mux3_i)) ? wb_data : rt_stored;
`else
  assign RSdata_o = rs_stored;
  assign RTdata_o = rt_stored;
`endif
endmodule
